// File: rtl/bcd_seq_conv.sv
// rtl/bcd_seq_conv.sv - sequential binary-to-BCD converter (shift-add-3), one bit per clock.
// Optional signed input selected by defining SIGNED_IN_EN.
module bcd_seq_conv #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  generate
    if (64'(10) ** DIGITS <= (64'(1) << BIN_W) - 64'(1)) begin : g_range_err
      $error("bcd_seq_conv: DIGITS too small for BIN_W");
    end
  endgenerate

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [BIN_W-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sign_q, sign_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               done_q, done_d;

  logic               in_neg;
  logic [BIN_W-1:0]   mag;
  logic [BCD_W-1:0]   adj;
  logic [BCD_W-1:0]   step_work;
  logic [BIN_W-1:0]   step_sh;

`ifdef SIGNED_IN_EN
  assign in_neg = bin[BIN_W-1];
  assign mag    = in_neg ? -bin : bin;
`else
  assign in_neg = 1'b0;
  assign mag    = bin;
`endif

  // Correct every nibble that would overflow past 9 after the doubling shift.
  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
    end
  end

  assign {step_work, step_sh} = {adj[BCD_W-2:0], shreg_q, 1'b0};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          shreg_d = mag;
          work_d  = '0;
          cnt_d   = '0;
          sign_d  = in_neg;
        end
      end
      SHIFT: begin
        work_d  = step_work;
        shreg_d = step_sh;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = IDLE;
          bcd_d   = step_work;
          neg_d   = sign_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// tb/tb_bcd_seq_conv.sv - directed and sweep checks for bcd_seq_conv.
// Honours SIGNED_IN_EN when defined for the build.
module tb_bcd_seq_conv;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        neg;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_seq_conv #(.BIN_W(12), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .neg   (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference by repeated division, independent of the shift-add-3 method.
  function automatic logic [16:0] model(input logic [11:0] b);
    int          m;
    logic        n;
    logic [15:0] r;
`ifdef SIGNED_IN_EN
    n = b[11];
    m = n ? 4096 - int'(b) : int'(b);
`else
    n = 1'b0;
    m = int'(b);
`endif
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {n, r};
  endfunction

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic convert(input string tag, input logic [11:0] b,
                         input logic [15:0] exp_bcd, input logic exp_neg);
    int lat;
    start = 1'b1;
    bin   = b;
    tick();
    start = 1'b0;
    bin   = ~b;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'd12);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    check({tag, "_neg"}, 32'(neg), 32'(exp_neg));
    check({tag, "_idle"}, 32'(busy), 32'd0);
    tick();
    check({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int          lat;
    int          ndone;
    logic [16:0] m;

    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd),  32'd0);
    check("rst_neg",  32'(neg),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    convert("t1_1234", 12'd1234, 16'h1234, 1'b0);
`ifdef SIGNED_IN_EN
    convert("t2_4095", 12'd4095, 16'h0001, 1'b1);
`else
    convert("t2_4095", 12'd4095, 16'h4095, 1'b0);
`endif
    convert("t2_zero", 12'd0, 16'h0000, 1'b0);

    // start while busy is ignored; start held into the done cycle is accepted
    start = 1'b1;
    bin   = 12'd7;
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      if (lat == 5) begin
        start = 1'b1;
        bin   = 12'd999;
      end
    end
    check("t3_lat", 32'(lat), 32'd12);
    check("t3_bcd", 32'(bcd), 32'h0007);
    bin = 12'd42;
    tick();
    start = 1'b0;
    check("t3_b2b_busy", 32'(busy), 32'd1);
    check("t3_b2b_done", 32'(done), 32'd0);
    wait_done(lat);
    check("t3_b2b_lat", 32'(lat), 32'd12);
    check("t3_b2b_bcd", 32'(bcd), 32'h0042);

    // async reset mid-conversion
    tick();
    start = 1'b1;
    bin   = 12'd500;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_done", 32'(done), 32'd0);
    check("t4_bcd",  32'(bcd),  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    check("t4_no_done", 32'(ndone), 32'd0);
    convert("t4_fresh", 12'd500, 16'h0500, 1'b0);

`ifdef SIGNED_IN_EN
    convert("t5_fff", 12'hFFF, 16'h0001, 1'b1);
    convert("t5_800", 12'h800, 16'h2048, 1'b1);
    convert("t5_7ff", 12'h7FF, 16'h2047, 1'b0);
`else
    convert("t6_800", 12'h800, 16'h2048, 1'b0);
`endif

    for (int v = 0; v < 4096; v++) begin
      m = model(12'(v));
      convert("sweep", 12'(v), m[15:0], m[16]);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
